fir_coef_ctrl: RTL

Configuration and sequencing controller placed between the sample source and `myfir`. It holds a shadow coefficient bank that software writes through a small register port. On command it commits the bank atomically at a sample boundary, optionally flushes the filter delay line with zero samples, and masks the filter outputs caused by those flush samples. Upstream is back-pressured with `RDY` while a commit is in progress.

---
 rtl/fir_ctrl_pkg.sv | 18 +
 rtl/fir_tag_pipe.sv | 27 ++
 rtl/fir_coef_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient controller.
// No logic here; imported by the controller top.
package fir_ctrl_pkg;

    localparam int NB_DEF = 16;

    localparam logic [1:0] ADDR_B0 = 2'd0;
    localparam logic [1:0] ADDR_B1 = 2'd1;
    localparam logic [1:0] ADDR_B2 = 2'd2;
    localparam logic [1:0] ADDR_B3 = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_APPLY = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/fir_tag_pipe.sv
// LAT-deep 1-bit delay line tracking which filter outputs stem from flush samples.
// Latency LAT cycles; no backpressure, shifts every cycle.
module fir_tag_pipe #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [LAT-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[LAT-1];

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient commit/flush sequencer in front of myfir: atomic shadow->active swap, zero flush, output masking.
// Samples reach the filter 1 cycle after acceptance; RDY drops for 1 (+FLUSH_LEN) cycles per commit.
module fir_coef_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int NB        = NB_DEF,
    parameter int FLUSH_LEN = 3,
    parameter int LAT       = 2
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          VIN,
    input  logic [NB-1:0] DIN,
    output logic          RDY,
    input  logic          WE,
    input  logic [1:0]    ADDR,
    input  logic [NB-1:0] WDATA,
    input  logic          COMMIT,
    input  logic          CLR_EN,
    output logic          F_VIN,
    output logic [NB-1:0] F_DIN,
    output logic [NB-1:0] B0,
    output logic [NB-1:0] B1,
    output logic [NB-1:0] B2,
    output logic [NB-1:0] B3,
    input  logic          VOUT,
    input  logic [NB-1:0] DOUT,
    output logic          O_VOUT,
    output logic [NB-1:0] O_DOUT,
    output logic          BUSY
);

    localparam int CW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          cnt_last;
    logic          serve;
    logic          clr_q;
    logic          pend_q;
    logic          pend_clr_q;
    logic          ftag;
    logic          tag_out;
    logic [NB-1:0] shadow [4];
    logic [NB-1:0] active [4];

    assign cnt_last = (cnt == CW'(FLUSH_LEN - 1));
    assign serve    = COMMIT | pend_q;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        RDY       = 1'b0;
        BUSY      = pend_q;
        case (state)
            ST_RUN: begin
                RDY = 1'b1;
                if (serve) begin
                    state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                BUSY      = 1'b1;
                state_nxt = clr_q ? ST_FLUSH : ST_RUN;
            end
            ST_FLUSH: begin
                BUSY = 1'b1;
                if (cnt_last) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                BUSY      = 1'b1;
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Sample path, flush counter and commit bookkeeping.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            F_VIN      <= 1'b0;
            F_DIN      <= '0;
            ftag       <= 1'b0;
            cnt        <= '0;
            clr_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_clr_q <= 1'b0;
        end else begin
            F_VIN <= 1'b0;
            ftag  <= 1'b0;
            case (state)
                ST_RUN: begin
                    F_VIN <= VIN;
                    F_DIN <= DIN;
                    cnt   <= '0;
                    if (serve) begin
                        clr_q  <= COMMIT ? CLR_EN : pend_clr_q;
                        pend_q <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    cnt <= '0;
                end
                ST_FLUSH: begin
                    F_VIN <= 1'b1;
                    F_DIN <= '0;
                    ftag  <= 1'b1;
                    cnt   <= cnt + CW'(1);
                end
                default: begin
                    cnt <= '0;
                end
            endcase
            // A commit arriving mid-sequence is parked; the latest CLR_EN wins.
            if (state != ST_RUN && COMMIT) begin
                pend_q     <= 1'b1;
                pend_clr_q <= CLR_EN;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (WE) begin
                shadow[ADDR] <= WDATA;
            end
            if (state == ST_APPLY) begin
                for (int i = 0; i < 4; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    assign B0 = active[ADDR_B0];
    assign B1 = active[ADDR_B1];
    assign B2 = active[ADDR_B2];
    assign B3 = active[ADDR_B3];

    fir_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk   (CLK),
        .rst_n (RST_n),
        .din   (ftag),
        .dout  (tag_out)
    );

    assign O_VOUT = VOUT & ~tag_out;
    assign O_DOUT = DOUT;

endmodule
